cache_arbiter: RTL

Arbiter and burst sequencer that shares the single burst memory port (`bmem_*`) between the instruction cache and the data cache in the cached (CP2+) configuration of `mp4`. Each cache issues whole-line (256-bit) read or write requests. The arbiter grants one cache at a time and runs a 4-beat, 64-bit burst on `bmem_*`. It assembles or slices the line and returns a one-cycle `resp` to the granted cache.

---
 rtl/cache_types.sv | 8 +
 rtl/line_buffer.sv | 36 +++
 rtl/cache_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cache_types.sv
// Shared types and line geometry for the I/D-cache burst arbiter.
package cache_types;
    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} arb_state_t;
    typedef enum logic       {REQ_I = 1'b0, REQ_D = 1'b1} arb_req_t;
endpackage

// File: rtl/line_buffer.sv
// Beat-addressed line register: whole-line load for writeback, per-beat fill for reads.
// Single-cycle write, combinational read; no flow control of its own.
module line_buffer #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64,
    localparam int IDX_W = $clog2(BEATS)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [BEATS*BEAT_W-1:0] load_line,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [BEAT_W-1:0]       wr_dat,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [BEAT_W-1:0]       rd_dat,
    output logic [BEATS*BEAT_W-1:0] line
);
    logic [BEAT_W-1:0] mem [BEATS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BEATS; i++) mem[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < BEATS; i++) mem[i] <= load_line[i*BEAT_W +: BEAT_W];
        end else if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

    for (genvar g = 0; g < BEATS; g++) begin : g_line
        assign line[g*BEAT_W +: BEAT_W] = mem[g];
    end
endmodule

// File: rtl/cache_arbiter.sv
// Shares one burst memory port between I- and D-cache; alternates grants on conflict.
// Request->bmem 1 cycle, resp after BEATS beats + 1; each bmem stall adds one cycle.
module cache_arbiter
    import cache_types::*;
#(
    parameter int BEATS  = 4,
    parameter int BEAT_W = LINE_W / BEATS
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             icache_address,
    input  logic                    icache_read,
    output logic [BEATS*BEAT_W-1:0] icache_rdata,
    output logic                    icache_resp,
    input  logic [31:0]             dcache_address,
    input  logic                    dcache_read,
    input  logic                    dcache_write,
    input  logic [BEATS*BEAT_W-1:0] dcache_wdata,
    output logic [BEATS*BEAT_W-1:0] dcache_rdata,
    output logic                    dcache_resp,
    output logic [31:0]             bmem_address,
    output logic                    bmem_read,
    output logic                    bmem_write,
    output logic [BEAT_W-1:0]       bmem_wdata,
    input  logic [BEAT_W-1:0]       bmem_rdata,
    input  logic                    bmem_resp
);
    localparam int          IDX_W     = $clog2(BEATS);
    localparam logic [31:0] LINE_MASK = ~32'((1 << OFFSET_BITS) - 1);

    arb_state_t state, next_state;
    arb_req_t   last_grant, grant_id;
    logic [IDX_W-1:0]        beat;
    logic [31:0]             addr_q;
    logic [BEATS*BEAT_W-1:0] buf_line, fill_line;
    logic [BEAT_W-1:0]       buf_rd;
    logic                    i_pend, d_pend, grant, grant_d, last_beat;

    assign i_pend    = icache_read;
    assign d_pend    = dcache_read | dcache_write;
    // On conflict the cache that did not win last time is served.
    assign grant_d   = d_pend & (~i_pend | (last_grant == REQ_I));
    assign last_beat = (beat == IDX_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state  = state;
        grant       = 1'b0;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        case (state)
            IDLE: begin
                if (i_pend | d_pend) begin
                    grant      = 1'b1;
                    next_state = (grant_d && dcache_write) ? WRITE : READ;
                end
            end
            READ: begin
                bmem_read = 1'b1;
                if (bmem_resp && last_beat) next_state = DONE;
            end
            WRITE: begin
                bmem_write = 1'b1;
                if (bmem_resp && last_beat) next_state = DONE;
            end
            DONE: begin
                icache_resp = (grant_id == REQ_I);
                dcache_resp = (grant_id == REQ_D);
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Final beat merged in flight so the line is complete in the DONE cycle.
    always_comb begin
        fill_line = buf_line;
        fill_line[beat*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant   <= REQ_I;
            grant_id     <= REQ_I;
            addr_q       <= '0;
            beat         <= '0;
            icache_rdata <= '0;
            dcache_rdata <= '0;
        end else begin
            if (grant) begin
                grant_id   <= arb_req_t'(grant_d);
                last_grant <= arb_req_t'(grant_d);
                addr_q     <= (grant_d ? dcache_address : icache_address) & LINE_MASK;
                beat       <= '0;
            end else if ((state == READ || state == WRITE) && bmem_resp && !last_beat) begin
                beat <= beat + IDX_W'(1);
            end
            if (state == READ && bmem_resp && last_beat) begin
                if (grant_id == REQ_D) dcache_rdata <= fill_line;
                else                   icache_rdata <= fill_line;
            end
        end
    end

    line_buffer #(.BEATS(BEATS), .BEAT_W(BEAT_W)) u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (grant & grant_d & dcache_write),
        .load_line (dcache_wdata),
        .wr_en     ((state == READ) & bmem_resp),
        .wr_idx    (beat),
        .wr_dat    (bmem_rdata),
        .rd_idx    (beat),
        .rd_dat    (buf_rd),
        .line      (buf_line)
    );

    assign bmem_address = addr_q;
    assign bmem_wdata   = (state == WRITE) ? buf_rd : '0;
endmodule
